// File: rtl/call_stack_ctrl_if.sv
// Control-unit and stack-memory signal bundle for call_stack_ctrl.
// master = control unit plus stack memory (environment); slave = call_stack_ctrl.
interface call_stack_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
);
   logic              call_req;
   logic              ret_req;
   logic [DATA_W-1:0] pc_in;
   logic              err_clr;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] ret_pc;
   logic [CNT_W-1:0]  depth;
   logic              err_overflow;
   logic              err_underflow;
   logic [CNT_W-1:0]  hwm;
   logic              stk_write;
   logic              stk_read;
   logic [DATA_W-1:0] stk_data_in;
   logic [DATA_W-1:0] stk_data_out;

   modport master (
      output call_req, ret_req, pc_in, err_clr, stk_data_out,
      input  busy, done, ret_pc, depth, err_overflow, err_underflow, hwm,
             stk_write, stk_read, stk_data_in
   );

   modport slave (
      input  call_req, ret_req, pc_in, err_clr, stk_data_out,
      output busy, done, ret_pc, depth, err_overflow, err_underflow, hwm,
             stk_write, stk_read, stk_data_in
   );
endinterface

// File: rtl/call_stack_ctrl.sv
// CALL/RET initiator for a 32x32 push/pop stack memory with shadow depth and sticky errors.
// Optional high-water mark tracking is enabled by defining STACK_HWM_EN.
module call_stack_ctrl #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 31,
   parameter int CNT_W  = 6
) (
   input logic              clock,
   input logic              clr_n,
   call_stack_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, PUSH, PUSH_END, POP, POP_CAP, FIN} state_t;

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  depth_q, depth_d;
   logic [DATA_W-1:0] ret_pc_q, ret_pc_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              wr_q, wr_d;
   logic              rd_q, rd_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   always_comb begin
      state_d  = state_q;
      depth_d  = depth_q;
      ret_pc_d = ret_pc_q;
      wdata_d  = wdata_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      // Clear first so an error raised on the same edge takes precedence.
      if (bus.err_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (bus.call_req) begin
               if (depth_q < FULL) begin
                  wdata_d = bus.pc_in;
                  state_d = PUSH;
               end else begin
                  ovf_d   = 1'b1;
                  state_d = FIN;
               end
            end else if (bus.ret_req) begin
               if (depth_q != '0) begin
                  state_d = POP;
               end else begin
                  unf_d   = 1'b1;
                  state_d = FIN;
               end
            end
         end
         PUSH:     state_d = PUSH_END;
         PUSH_END: begin
            depth_d = depth_q + CNT_W'(1);
            state_d = FIN;
         end
         POP:      state_d = POP_CAP;
         POP_CAP: begin
            ret_pc_d = bus.stk_data_out;
            depth_d  = depth_q - CNT_W'(1);
            state_d  = FIN;
         end
         FIN:      state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      // Outputs are registered from the next state so strobes are glitch-free.
      wr_d   = (state_d == PUSH);
      rd_d   = (state_d == POP);
      done_d = (state_d == FIN);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         state_q  <= IDLE;
         depth_q  <= '0;
         ret_pc_q <= '0;
         wdata_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         depth_q  <= depth_d;
         ret_pc_q <= ret_pc_d;
         wdata_q  <= wdata_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

`ifdef STACK_HWM_EN
   logic [CNT_W-1:0] hwm_q, hwm_d;

   assign hwm_d = (depth_d > hwm_q) ? depth_d : hwm_q;

   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) hwm_q <= '0;
      else        hwm_q <= hwm_d;
   end

   assign bus.hwm = hwm_q;
`else
   assign bus.hwm = '0;
`endif

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.ret_pc        = ret_pc_q;
   assign bus.depth         = depth_q;
   assign bus.err_overflow  = ovf_q;
   assign bus.err_underflow = unf_q;
   assign bus.stk_write     = wr_q;
   assign bus.stk_read      = rd_q;
   assign bus.stk_data_in   = wdata_q;

endmodule

// File: doc/call_stack_ctrl.md
Name: call_stack_ctrl

Overview:
- Initiator side of the 32x32 push/pop stack memory. Converts CALL/RET requests from the control unit into single-cycle write/read strobes on the stack port, then captures the popped return address.
- The stack memory is level/edge-sensitive on read and write and has no full/empty outputs, so this block keeps a shadow depth count and performs all overflow/underflow checking.
- Sits between the control unit and the stack memory.

Parameters:
- DATA_W, 32, width of pushed/popped words (PC width).
- DEPTH, 31, usable stack entries (stack pointer starts at 1 in a 32-entry array).
- CNT_W, 6, width of depth counter; must hold 0..DEPTH.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clr_n  in  1  reset; asynchronous assert, active-low.
- call_req  in  1  level request: push pc_in.
- ret_req  in  1  level request: pop into ret_pc.
- pc_in  in  DATA_W  return address to push; sampled on call acceptance.
- err_clr  in  1  synchronous clear of sticky error flags.
- busy  out  1  high whenever FSM is not IDLE.
- done  out  1  one-cycle pulse when an operation (or a rejected one) completes.
- ret_pc  out  DATA_W  last popped value; holds between pops.
- depth  out  CNT_W  current number of valid entries.
- err_overflow  out  1  sticky; a CALL was rejected because the stack was full.
- err_underflow  out  1  sticky; a RET was rejected because the stack was empty.
- hwm  out  CNT_W  high-water mark (see Optional Feature).
- stk_write  out  1  write strobe to stack memory.
- stk_read  out  1  read strobe to stack memory.
- stk_data_in  out  DATA_W  data to stack memory.
- stk_data_out  in  DATA_W  data from stack memory.

Behaviour:
- Reset (clr_n=0, async): FSM=IDLE.
  - Outputs: busy=0, done=0, ret_pc=0, depth=0, both error flags=0, hwm=0, stk_write=0, stk_read=0, stk_data_in=0.
  - The stack memory has no reset. clr_n is a system-wide reset only, and the stack memory must be reinitialised with it.
  - Reset mid-operation aborts immediately: strobes drop to 0 asynchronously, and depth is not updated.
- FSM states: IDLE, PUSH, PUSH_END, POP, POP_CAP, FIN. Requests are accepted only in IDLE.
- Request priority in IDLE:
  - call_req has priority over ret_req. If both are high, the RET is not accepted and must be held.
  - call_req=1, depth<DEPTH: latch pc_in into stk_data_in, go to PUSH.
  - call_req=1, depth==DEPTH: set err_overflow, go to FIN. No strobe, depth unchanged.
  - ret_req=1 (no call), depth>0: go to POP.
  - ret_req=1 (no call), depth==0: set err_underflow, go to FIN. ret_pc unchanged.
- PUSH: stk_write=1 for exactly one cycle, then go to PUSH_END.
- PUSH_END: stk_write=0, depth+=1, go to FIN.
- POP: stk_read=1 for exactly one cycle, then go to POP_CAP.
- POP_CAP: stk_read=0, ret_pc<=stk_data_out, depth-=1, go to FIN.
- FIN: done=1 for one cycle, go to IDLE.
- Latency, counted from the accepting edge: done high 3 cycles later for a push or pop, 1 cycle later for a rejected request. A new request can be accepted on the edge after done.
- Strobes:
  - stk_write and stk_read are never high together.
  - Each strobe is preceded and followed by at least one low cycle, so the stack memory sees clean edges.
  - stk_data_in is stable from PUSH through PUSH_END.
- Requests held high across done are treated as new requests, so back-to-back operations are allowed.
- depth never wraps; saturation is enforced by the rejection rules above.
- err_clr=1 clears both error flags on the next edge. If err_clr and a new error occur on the same edge, the error wins.

Optional Feature:
- Macro: STACK_HWM_EN.
- Defined: hwm tracks the maximum depth since reset. It updates in the same cycle as depth and is unaffected by err_clr.
- Undefined: hwm is tied to 0 and no tracking register exists.

Test Plan:
- Push, then pop: after reset, call_req with pc_in=0x0000_1234 → stk_write pulse one cycle, done 3 cycles later, depth=1. Then ret_req with the stack returning 0x0000_1234 → stk_read pulse, ret_pc=0x0000_1234, depth=0.
- Underflow: after reset, ret_req → no strobes, done after 1 cycle, err_underflow=1, ret_pc=0. Then err_clr → err_underflow=0.
- Overflow: 31 calls with pc_in=1..31 → depth=31. A 32nd call → no stk_write, err_overflow=1, depth stays 31. Then 31 returns → ret_pc sequence 31..1, depth=0.
- Simultaneous requests: call_req and ret_req high together at depth=2 → push performed, depth=3. RET held high → pop follows, depth=2.
- Reset mid-operation: assert clr_n=0 during PUSH → stk_write drops to 0 immediately. After release, depth=0 and busy=0.
- hwm: with STACK_HWM_EN defined, 5 calls then 3 returns → hwm=5, depth=2. With the macro undefined → hwm=0 throughout.
